pipe_reg_chain: RTL and testbench

//  Parametrised elastic register pipeline: DEPTH stages of BW_DATA-bit registers with
//  per-stage valid bits, valid/ready flow control, bubble collapsing and synchronous flush.

---
 rtl/pipe_reg_chain.sv | 70 +++++++
 tb/tb_pipe_reg_chain.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Define PIPE_DATA_RST_EN to also reset the data registers to RST_VAL.
module pipe_reg_chain #(
   parameter int BW_DATA = 32,
   parameter int DEPTH = 4,
   parameter logic [BW_DATA-1:0] RST_VAL = '0,
   localparam int BW_CNT = $clog2(DEPTH+1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_d,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_DATA-1:0] o_q,
   input  logic               i_flush,
   output logic [BW_CNT-1:0]  o_count
);
   logic [DEPTH-1:0] v, adv, vin;
   logic [BW_DATA-1:0] d [DEPTH];
   logic [BW_DATA-1:0] din [DEPTH];
   logic [BW_CNT-1:0] cnt;
   logic in_xfer, out_xfer;
   genvar s;
   for (s = 0; s < DEPTH; s++) begin : g_stage
      // a stage can move unless it and every stage downstream are full while the sink stalls
      assign adv[s] = i_ready | ~&v[DEPTH-1:s];
      if (s == 0) begin : g_head
         assign vin[s] = i_valid;
         assign din[s] = i_d;
      end else begin : g_body
         assign vin[s] = v[s-1];
         assign din[s] = d[s-1];
      end
   end
   assign o_ready = adv[0];
   assign o_valid = v[DEPTH-1];
   assign o_q = d[DEPTH-1];
   assign o_count = cnt;
   assign in_xfer = i_valid & adv[0];
   assign out_xfer = v[DEPTH-1] & i_ready;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         v <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            if (adv[k]) v[k] <= vin[k];
      end
   end
`ifdef PIPE_DATA_RST_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < DEPTH; k++) d[k] <= RST_VAL;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            if (adv[k] && vin[k]) d[k] <= din[k];
      end
   end
`else
   // data only loads with a valid item, so bubbles never overwrite held values
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < DEPTH; k++)
         if (adv[k] && vin[k]) d[k] <= din[k];
   end
`endif
   always_ff @(posedge i_clk) begin
      cnt <= (i_rst || i_flush) ? '0 : cnt + BW_CNT'(in_xfer) - BW_CNT'(out_xfer);
   end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain (DEPTH=4 main instance, DEPTH=1 side instance).
module tb_pipe_reg_chain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
   logic [31:0] i_d = '0;
   logic o_ready, o_valid;
   logic [31:0] o_q;
   logic [2:0] o_count;
   logic b_valid = 1'b0, b_rdy = 1'b0;
   logic [31:0] b_d = '0;
   logic b_ready, b_ov;
   logic [31:0] b_q;
   logic [0:0] b_cnt;
   int n_chk = 0, n_err = 0;
   int cyc_n = 0, first_acc = -1, first_out = -1, last_out_c = -1;
   logic last_in, last_out;
   logic [2:0] cnt_m = '0;
   logic [31:0] q [$];
   always #5 clk = ~clk;
   pipe_reg_chain #(.BW_DATA(32), .DEPTH(4), .RST_VAL(32'hDEADBEEF)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_d(i_d),
      .o_valid(o_valid), .i_ready(i_ready), .o_q(o_q), .i_flush(i_flush), .o_count(o_count));
   pipe_reg_chain #(.BW_DATA(32), .DEPTH(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_d(b_d),
      .o_valid(b_ov), .i_ready(b_rdy), .o_q(b_q), .i_flush(1'b0), .o_count(b_cnt));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one cycle on the main instance: drive, score transfers, step to next negedge
   task automatic cyc(input logic vld, input logic [31:0] dat, input logic rdy, input logic fl);
      logic inx, outx;
      i_valid = vld; i_d = dat; i_ready = rdy; i_flush = fl;
      #1;
      inx = vld & o_ready;
      outx = o_valid & rdy;
      if (outx) begin
         if (q.size() == 0) chk("sb_unexpected", {31'd0, o_valid}, 32'd0);
         else chk("sb_data", o_q, q.pop_front());
         if (first_out < 0) first_out = cyc_n;
         last_out_c = cyc_n;
      end
      if (inx) begin
         q.push_back(dat);
         if (first_acc < 0) first_acc = cyc_n;
      end
      if (fl) q.delete();
      last_in = inx;
      last_out = outx;
      cnt_m = fl ? 3'd0 : cnt_m + 3'(inx) - 3'(outx);
      cyc_n++;
      @(negedge clk);
      chk("count", {29'd0, o_count}, {29'd0, cnt_m});
   endtask
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drained", q.size(), 0);
   endtask
   initial begin
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", {31'd0, o_valid}, 0);
      chk("rst_count", {29'd0, o_count}, 0);
      chk("rst_ready", {31'd0, o_ready}, 1);
`ifdef PIPE_DATA_RST_EN
      chk("rst_q", o_q, 32'hDEADBEEF);
`endif
      // 1: stream 1..8 with open sink
      for (int i = 0; i < 8; i++) begin
         if (i >= 4) chk("t1_steady", {29'd0, o_count}, 4);
         cyc(1'b1, 32'(i + 1), 1'b1, 1'b0);
      end
      drain(8);
      chk("t1_latency", first_out - first_acc, 4);
      chk("t1_span", last_out_c - first_out, 7);
      // 2: fill against a stalled sink, then release
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
         if (last_in) n++;
      end
      chk("t2_accepted", n, 4);
      chk("t2_full_count", {29'd0, o_count}, 4);
      chk("t2_full_ready", {31'd0, o_ready}, 0);
      i_valid = 1'b0; i_ready = 1'b1;
      #1;
      chk("t2_ready_rise", {31'd0, o_ready}, 1);
      drain(6);
      // 3: bubbly input against a stalled sink compacts to a full pipe
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc((i < 4) ? ~i[0] : 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
         if (last_in) n++;
         chk("t3_ready", {31'd0, o_ready}, {31'd0, o_count != 3'd4});
      end
      chk("t3_accepted", n, 4);
      drain(6);
      // 4: flush with three stored and one presented
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
      chk("t4_pre_count", {29'd0, o_count}, 3);
      cyc(1'b1, 32'hF00D, 1'b0, 1'b1);
      chk("t4_valid", {31'd0, o_valid}, 0);
      chk("t4_count", {29'd0, o_count}, 0);
      drain(6);
      cyc(1'b1, 32'h3AA, 1'b1, 1'b0);
      drain(6);
      // 5: reset mid-stream
      cyc(1'b1, 32'h400, 1'b0, 1'b0);
      cyc(1'b1, 32'h401, 1'b0, 1'b0);
      chk("t5_pre_count", {29'd0, o_count}, 2);
      rst = 1'b1; i_valid = 1'b1; i_d = 32'h402;
      @(negedge clk);
      rst = 1'b0; i_valid = 1'b0;
      #1;
      q.delete();
      cnt_m = '0;
      chk("t5_valid", {31'd0, o_valid}, 0);
      chk("t5_count", {29'd0, o_count}, 0);
      chk("t5_ready", {31'd0, o_ready}, 1);
`ifdef PIPE_DATA_RST_EN
      chk("t5_q", o_q, 32'hDEADBEEF);
`endif
      cyc(1'b1, 32'h500, 1'b1, 1'b0);
      drain(6);
      // 6: DEPTH=1 instance
      b_valid = 1'b1; b_d = 32'hA5; b_rdy = 1'b0;
      #1;
      chk("t6_ready", {31'd0, b_ready}, 1);
      @(negedge clk);
      chk("t6_valid", {31'd0, b_ov}, 1);
      chk("t6_q", b_q, 32'hA5);
      chk("t6_count", {31'd0, b_cnt}, 1);
      for (int k = 0; k < 6; k++) begin
         b_valid = 1'b1; b_d = 32'hB0 + 32'(k); b_rdy = 1'b1;
         #1;
         chk("t6_thru_ready", {31'd0, b_ready}, 1);
         @(negedge clk);
         chk("t6_thru_valid", {31'd0, b_ov}, 1);
         chk("t6_thru_q", b_q, 32'hB0 + 32'(k));
      end
      b_valid = 1'b0;
      @(negedge clk);
      chk("t6_empty", {31'd0, b_ov}, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
